// File: rtl/cmp_seq.sv
// cmp_seq: multi-cycle compare unit. Subtracts b from a CHUNK bits per cycle,
// LSB first, then evaluates one of eight compare modes from the N/Z/V/C flags
// of the full-width difference. Valid/ready handshakes on both sides.
module cmp_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags
);

  localparam int unsigned NCYC = WIDTH / CHUNK;
  localparam int unsigned CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    MODE_EQ   = 3'b000,
    MODE_NE   = 3'b001,
    MODE_SLT  = 3'b010,
    MODE_SLTE = 3'b011,
    MODE_ULT  = 3'b100,
    MODE_ULTE = 3'b101,
    MODE_SGT  = 3'b110,
    MODE_UGT  = 3'b111
  } mode_e;

  state_e           state_q;
  mode_e            mode_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic [WIDTH-1:0] a_d, b_d, diff_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             zacc_q;
  logic [WIDTH-1:0] out_q;
  logic [3:0]       flags_q;

  logic [CHUNK-1:0] a_chunk, b_inv;
  logic [CHUNK:0]   sum_d;
  logic [CHUNK-1:0] d;
  logic             cy, cin_msb;
  logic             n_d, z_d, v_d, c_d, lt_d, res_d;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign flags     = flags_q;

  // Chunk adder plus flag/result evaluation for the current chunk. Operands
  // are shifted right each cycle so the active chunk is always the low CHUNK
  // bits; the difference is shifted in from the top so it ends up aligned.
  always_comb begin
    a_chunk = a_q[CHUNK-1:0];
    b_inv   = ~b_q[CHUNK-1:0];
    sum_d   = {1'b0, a_chunk} + {1'b0, b_inv} + {{CHUNK{1'b0}}, carry_q};
    d       = sum_d[CHUNK-1:0];
    cy      = sum_d[CHUNK];
    // Sum bit = a ^ ~b ^ cin, so the carry into the chunk's top bit falls out
    // of the sum bit without a separate narrower adder.
    cin_msb = a_chunk[CHUNK-1] ^ b_inv[CHUNK-1] ^ d[CHUNK-1];
    n_d     = d[CHUNK-1];
    z_d     = zacc_q & (d == '0);
    v_d     = cin_msb ^ cy;
    c_d     = cy;
    lt_d    = n_d ^ v_d;
    a_d     = a_q >> CHUNK;
    b_d     = b_q >> CHUNK;
    diff_d  = diff_q >> CHUNK;
    diff_d[WIDTH-1 -: CHUNK] = d;
    res_d   = 1'b0;
    case (mode_q)
      MODE_EQ:   res_d = z_d;
      MODE_NE:   res_d = ~z_d;
      MODE_SLT:  res_d = lt_d;
      MODE_SLTE: res_d = lt_d | z_d;
      MODE_ULT:  res_d = ~c_d;
      MODE_ULTE: res_d = ~c_d | z_d;
      MODE_SGT:  res_d = ~lt_d & ~z_d;
      MODE_UGT:  res_d = c_d & ~z_d;
      default:   res_d = 1'b0;
    endcase
  end

  // Control FSM with registered datapath state and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_EQ;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            mode_q  <= mode_e'(mode);
            cnt_q   <= '0;
            zacc_q  <= 1'b1;
            carry_q <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_d;
          b_q     <= b_d;
          diff_q  <= diff_d;
          carry_q <= cy;
          zacc_q  <= z_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            out_q   <= {{(WIDTH-1){1'b0}}, res_d};
            flags_q <= {n_d, z_d, v_d, c_d};
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_seq.sv
module tb_cmp_seq;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] a, b;
  logic [2:0]  mode;
  logic        out_valid, out_ready;
  logic [15:0] out16;
  logic [3:0]  flags;

  logic        in_valid32, out_ready32;
  logic [31:0] a32, b32;
  logic [2:0]  mode32;
  logic [2:0]  in_ready32, out_valid32;
  logic [31:0] o32 [3];
  logic [3:0]  f32 [3];

  int tests;
  int failed;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  mode;
    logic [15:0] exp_out;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vecs[$];

  cmp_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out(out16), .flags(flags)
  );

  cmp_seq #(.WIDTH(32), .CHUNK(8)) dut_c8 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32[0]),
    .a(a32), .b(b32), .mode(mode32), .out_valid(out_valid32[0]),
    .out_ready(out_ready32), .out(o32[0]), .flags(f32[0])
  );

  cmp_seq #(.WIDTH(32), .CHUNK(32)) dut_c32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32[1]),
    .a(a32), .b(b32), .mode(mode32), .out_valid(out_valid32[1]),
    .out_ready(out_ready32), .out(o32[1]), .flags(f32[1])
  );

  cmp_seq #(.WIDTH(32), .CHUNK(1)) dut_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32[2]),
    .a(a32), .b(b32), .mode(mode32), .out_valid(out_valid32[2]),
    .out_ready(out_ready32), .out(o32[2]), .flags(f32[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Independent reference: {res, N, Z, V, C} from full-width arithmetic.
  function automatic logic [4:0] ref32(input logic [31:0] x, input logic [31:0] y,
                                       input logic [2:0] m);
    logic [31:0] df;
    logic n, z, v, c, lt, r;
    df = x - y;
    n  = df[31];
    z  = (x == y);
    c  = (x >= y);
    v  = (x[31] != y[31]) && (df[31] != x[31]);
    lt = n ^ v;
    case (m)
      3'd0: r = z;
      3'd1: r = !z;
      3'd2: r = lt;
      3'd3: r = lt | z;
      3'd4: r = !c;
      3'd5: r = !c | z;
      3'd6: r = !lt & !z;
      default: r = c & !z;
    endcase
    return {r, n, z, v, c};
  endfunction

  // Runs one op on the 16-bit unit; called just after a rising edge while idle.
  task automatic do_op16(input logic [15:0] xa, input logic [15:0] xb, input logic [2:0] xm,
                         output logic [15:0] o, output logic [3:0] f, output int lat);
    bit got;
    a = xa; b = xb; mode = xm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); mode = 3'($urandom);
    lat = 0; got = 0;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) begin got = 1; break; end
    end
    if (!got) chk("op16_timeout", 32'd0, 32'd1);
    o = out16; f = flags;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] o;
    logic [3:0]  f;
    int          lat;
    int          t [3];
    bit          found, ov_seen;
    int          lat32 [3];
    logic [31:0] ro32 [3];
    logic [3:0]  rf32 [3];
    logic [4:0]  r;
    int          exp_lat [3];
    logic [31:0] x, y;

    tests = 0; failed = 0;
    exp_lat[0] = 4; exp_lat[1] = 1; exp_lat[2] = 32;

    // a, b, mode, out, flags{N,Z,V,C}
    vecs.push_back('{16'h7FFF, 16'h8000, 3'd3, 16'h0000, 4'b1010});
    vecs.push_back('{16'h8000, 16'h7FFF, 3'd3, 16'h0001, 4'b0011});
    vecs.push_back('{16'h1234, 16'h1234, 3'd0, 16'h0001, 4'b0101});
    vecs.push_back('{16'h1234, 16'h1234, 3'd1, 16'h0000, 4'b0101});
    vecs.push_back('{16'h1234, 16'h1234, 3'd2, 16'h0000, 4'b0101});
    vecs.push_back('{16'h1234, 16'h1234, 3'd3, 16'h0001, 4'b0101});
    vecs.push_back('{16'h1234, 16'h1234, 3'd4, 16'h0000, 4'b0101});
    vecs.push_back('{16'h1234, 16'h1234, 3'd5, 16'h0001, 4'b0101});
    vecs.push_back('{16'h1234, 16'h1234, 3'd6, 16'h0000, 4'b0101});
    vecs.push_back('{16'h1234, 16'h1234, 3'd7, 16'h0000, 4'b0101});
    vecs.push_back('{16'hFFFF, 16'h0001, 3'd2, 16'h0001, 4'b1001});
    vecs.push_back('{16'hFFFF, 16'h0001, 3'd4, 16'h0000, 4'b1001});
    vecs.push_back('{16'hFFFF, 16'h0001, 3'd7, 16'h0001, 4'b1001});
    vecs.push_back('{16'hFFFF, 16'h0001, 3'd6, 16'h0000, 4'b1001});
    vecs.push_back('{16'h0003, 16'h0005, 3'd4, 16'h0001, 4'b1000});
    vecs.push_back('{16'h0005, 16'h0003, 3'd6, 16'h0001, 4'b0001});
    vecs.push_back('{16'h8000, 16'h0001, 3'd2, 16'h0001, 4'b0011});
    vecs.push_back('{16'h0000, 16'h0000, 3'd1, 16'h0000, 4'b0101});

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; mode = '0;
    in_valid32 = 1'b0; out_ready32 = 1'b0; a32 = '0; b32 = '0; mode32 = '0;
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out", {16'd0, out16}, 32'd0);
    chk("reset_flags", {28'd0, flags}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Directed table
    foreach (vecs[i]) begin
      do_op16(vecs[i].a, vecs[i].b, vecs[i].mode, o, f, lat);
      chk($sformatf("vec%0d_out", i), {16'd0, o}, {16'd0, vecs[i].exp_out});
      chk($sformatf("vec%0d_flags", i), {28'd0, f}, {28'd0, vecs[i].exp_flags});
      chk($sformatf("vec%0d_latency", i), lat, 32'd4);
    end

    // Backpressure: result held while out_ready is low
    a = 16'h0005; b = 16'h0003; mode = 3'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
    ov_seen = 0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      if (out_valid) begin ov_seen = 1; break; end
    end
    chk("bp_valid_seen", {31'd0, ov_seen}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_out_c%0d", k), {16'd0, out16}, 32'd1);
      chk($sformatf("bp_flags_c%0d", k), {28'd0, flags}, 32'b0001);
      chk($sformatf("bp_in_ready_c%0d", k), {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
    chk("bp_out_valid_after", {31'd0, out_valid}, 32'd0);

    // Reset two cycles into RUN
    a = 16'h7FFF; b = 16'h8000; mode = 3'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_out", {16'd0, out16}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("rst_accept_ignored", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    rst = 1'b0;
    ov_seen = 0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen = 1;
    end
    chk("rst_no_valid", {31'd0, ov_seen}, 32'd0);
    do_op16(16'd3, 16'd5, 3'd4, o, f, lat);
    chk("post_rst_out", {16'd0, o}, 32'd1);
    chk("post_rst_latency", lat, 32'd4);

    // Back-to-back with out_ready tied high: one op every 6 cycles
    a = 16'h0005; b = 16'h0003; mode = 3'd6;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      found = 0;
      for (int j = 0; j < 20; j++) begin
        @(negedge clk);
        if (in_ready) begin t[k] = $rtoi($time / 10); found = 1; break; end
      end
      chk($sformatf("b2b_accept%0d", k), {31'd0, found}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("b2b_gap01", t[1] - t[0], 32'd6);
    chk("b2b_gap12", t[2] - t[1], 32'd6);
    found = 0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      if (in_ready) begin found = 1; break; end
    end
    chk("b2b_drain", {31'd0, found}, 32'd1);
    out_ready = 1'b0;

    // WIDTH=32 sweep over CHUNK=8/32/1 against the reference model
    for (int m = 0; m < 8; m++) begin
      for (int rep = 0; rep < 3; rep++) begin
        x = $urandom;
        y = (rep == 0) ? x : ((rep == 1) ? {~x[31], x[30:0]} : $urandom);
        r = ref32(x, y, 3'(m));
        a32 = x; b32 = y; mode32 = 3'(m); in_valid32 = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0; a32 = $urandom; b32 = $urandom; mode32 = 3'($urandom);
        for (int i = 0; i < 3; i++) lat32[i] = 0;
        for (int cnt = 1; cnt <= 40; cnt++) begin
          @(posedge clk); #1;
          for (int i = 0; i < 3; i++) begin
            if (out_valid32[i] && lat32[i] == 0) begin
              lat32[i] = cnt; ro32[i] = o32[i]; rf32[i] = f32[i];
            end
          end
          if (lat32[0] != 0 && lat32[1] != 0 && lat32[2] != 0) break;
        end
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("sw_m%0d_r%0d_d%0d_lat", m, rep, i), lat32[i], exp_lat[i]);
          if (lat32[i] != 0) begin
            chk($sformatf("sw_m%0d_r%0d_d%0d_out", m, rep, i), ro32[i], {31'd0, r[4]});
            chk($sformatf("sw_m%0d_r%0d_d%0d_flags", m, rep, i), {28'd0, rf32[i]}, {28'd0, r[3:0]});
          end
        end
        out_ready32 = 1'b1;
        @(posedge clk); #1;
        out_ready32 = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/cmp_seq.md
# cmp_seq

Parametrised, multi-cycle compare unit for the ALU datapath, successor to the single-mode 16-bit signed less-or-equal compare. It subtracts `b` from `a` CHUNK bits per cycle, LSB first, and evaluates one of eight compare modes from the N/Z/V/C flags of the full-width difference. Signed compares use `N xor V`, so they remain correct when the subtraction overflows. Operands enter and results leave through valid/ready handshakes. The result is a WIDTH-bit boolean word (`1` or `0`) that can be written straight back to a register.

## Interface
- `WIDTH`, default 16: operand and result width; must be at least 2.
- `CHUNK`, default 4: bits subtracted per cycle.
  - Must divide WIDTH.
  - NCYC = WIDTH/CHUNK.
- `clk` input, 1 bit: the single clock; all state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `in_valid` input, 1 bit: `a`, `b` and `mode` are presented.
- `in_ready` output, 1 bit: the unit can accept an operation.
- `a` input, WIDTH bits: minuend.
- `b` input, WIDTH bits: subtrahend.
- `mode` input, 3 bits: compare select.
  - 000 EQ, 001 NE.
  - 010 SLT, 011 SLTE.
  - 100 ULT, 101 ULTE.
  - 110 SGT, 111 UGT.
- `out_valid` output, 1 bit: `out` and `flags` are valid.
- `out_ready` input, 1 bit: the consumer accepts the result.
- `out` output, WIDTH bits: `{WIDTH-1 zeros, res}`.
- `flags` output, 4 bits: `{N, Z, V, C}` of `a - b`. C = 1 means no borrow, i.e. `a >= b` unsigned.

## Operation
- States: IDLE, RUN, DONE.
  - `in_ready` = (state == IDLE).
  - `out_valid` = (state == DONE).
- IDLE: on `in_valid & in_ready`:
  - Latch `a`, `b` and `mode`.
  - Clear the chunk counter to 0 and the zero accumulator to 1.
  - Set carry to 1 (the two's-complement +1).
  - Go to RUN.
- RUN, each cycle:
  - Compute `{cy, d} = a_chunk + ~b_chunk + carry` for the chunk selected by the counter, LSB chunk first.
  - Store `d` in the difference register.
  - Update carry to `cy`; AND the zero accumulator with `(d == 0)`.
  - Increment the counter.
- After chunk NCYC-1:
  - N = diff[WIDTH-1]; Z = accumulator; C = final carry.
  - V = carry into the MSB xor carry out of the MSB. Track the carry into bit WIDTH-1 inside the top chunk.
  - Register `out` and `flags`; go to DONE.
- res per mode:
  - EQ = Z; NE = !Z.
  - SLT = N^V; SLTE = (N^V) | Z; SGT = !(N^V) & !Z.
  - ULT = !C; ULTE = !C | Z; UGT = C & !Z.
- DONE:
  - `out` and `flags` stay constant until `out_valid & out_ready`, then the unit goes to IDLE.
  - No new operation is accepted in the DONE cycle; `in_ready` = 0.
- Inputs `a`, `b` and `mode` are ignored outside the accept cycle. Changing them mid-operation has no effect.
- Reset, at any time including mid-RUN or during DONE:
  - State goes to IDLE and the operation in flight is discarded.
  - `out` = 0, `flags` = 0, `out_valid` = 0, counter = 0.
  - `in_ready` = 1 while `rst` is high and after it; accepts are ignored while `rst` is high.

## Timing
- Accept on edge T0; chunks are processed on edges T1..T(NCYC); `out_valid` rises after edge T(NCYC).
  - Latency: NCYC cycles from accept to result.
  - Defaults: 4 cycles. CHUNK=WIDTH: 1 cycle.
- If `out_ready` is already high, the result is consumed on edge T(NCYC+1) and `in_ready` is high after it.
  - Peak throughput: one op per NCYC+2 cycles.
- No combinational path from any input to any output; `in_ready` and `out_valid` are decoded from state only.

## Test plan
- Overflow case, defaults:
  - a=0x7FFF, b=0x8000, SLTE -> out=0x0000, flags N=1 V=1 Z=0 C=0. The naive sign-of-difference compare would return 1.
  - Swap the operands -> out=0x0001.
- Equality, a=b=0x1234:
  - EQ, SLTE and ULTE -> 0x0001.
  - NE, SLT, ULT, SGT and UGT -> 0x0000.
  - flags Z=1 C=1.
- Unsigned vs signed, a=0xFFFF, b=0x0001:
  - SLT -> 0x0001.
  - ULT -> 0x0000.
  - UGT -> 0x0001.
- Backpressure:
  - Hold `out_ready` low for 5 cycles after `out_valid` -> `out`/`flags` are stable and `in_ready` stays 0.
  - Pulse `out_ready` -> `in_ready` = 1 on the next cycle.
  - Back-to-back ops with `out_ready` tied high complete every 6 cycles.
- Reset two cycles into RUN:
  - `out_valid` never asserts for the aborted op and all outputs read 0.
  - A following op (a=3, b=5, ULT) returns 0x0001 after 4 cycles.
- Parameter sweep: WIDTH=32 with CHUNK=8, 32 and 1, and random operands in all 8 modes.
  - Results match the reference model.
  - Latency = 4, 1 and 32 cycles respectively.
